yutorina_alu: RTL and testbench

- Combinational integer ALU for the Yutorina CPU EX stage.
- Computes `out` from `op`, `lhs` and `rhs` in the same cycle. The EX stage uses it both as the EX/MEM pipeline-register input and as the forwarding value, so it must be zero-latency.
- Also produces combinational overflow and status flags, plus a registered copy of the flags for later condition use.

---
 rtl/yutorina_alu_pkg.sv | 27 ++
 rtl/yutorina_alu_addsub.sv | 21 ++
 rtl/yutorina_alu.sv | 90 +++++++++
 tb/tb_yutorina_alu.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/yutorina_alu_pkg.sv
// Shared ISA definitions for the Yutorina EX-stage ALU: bus widths and opcode encodings.
package yutorina_alu_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int ALU_OP_W    = 4;
  localparam int ALU_SHAMT_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_OP_NOP   = 4'd0,
    ALU_OP_AND   = 4'd1,
    ALU_OP_OR    = 4'd2,
    ALU_OP_XOR   = 4'd3,
    ALU_OP_ADDS  = 4'd4,
    ALU_OP_ADDU  = 4'd5,
    ALU_OP_SUBS  = 4'd6,
    ALU_OP_SUBU  = 4'd7,
    ALU_OP_SHRL  = 4'd8,
    ALU_OP_SHLL  = 4'd9,
    ALU_OP_SHRA  = 4'd10,
    ALU_OP_SLT   = 4'd11,
    ALU_OP_SLTU  = 4'd12,
    ALU_OP_NOR   = 4'd13,
    ALU_OP_PASSB = 4'd14,
    ALU_OP_RSVD  = 4'd15
  } alu_op_e;

endpackage

// File: rtl/yutorina_alu_addsub.sv
// Shared adder/subtractor: b is inverted and carry-in set for subtraction, so carry-out
// doubles as the unsigned no-borrow flag.
module yutorina_alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH-1:0] w_b;

  assign w_b = i_sub ? ~i_b : i_b;
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_sub};
  // Signed overflow: effective operands share a sign that the result does not.
  assign o_ovf = (i_a[WIDTH-1] == w_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/yutorina_alu.sv
// Zero-latency integer ALU for the Yutorina EX stage with combinational {N,Z,C,V}
// flags and a registered copy for later condition evaluation.
module yutorina_alu
  import yutorina_alu_pkg::*;
#(
  parameter int WIDTH   = WORD_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int SHAMT_W = ALU_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic [WIDTH-1:0] out,
  output logic             of,
  output logic [3:0]       flags,
  output logic [3:0]       flags_q
);

  logic [WIDTH-1:0]        w_sum;
  logic                    w_carry;
  logic                    w_ovf;
  logic                    w_sub;
  logic [SHAMT_W-1:0]      w_shamt;
  logic signed [WIDTH-1:0] w_lhs_s;
  logic [WIDTH-1:0]        w_out;
  logic                    w_of;
  logic                    w_c;
  logic [3:0]              r_flags_p1;

  assign w_sub   = (op == ALU_OP_SUBS) || (op == ALU_OP_SUBU) ||
                   (op == ALU_OP_SLT)  || (op == ALU_OP_SLTU);
  assign w_shamt = rhs[SHAMT_W-1:0];
  assign w_lhs_s = $signed(lhs);

  yutorina_alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .i_a    (lhs),
    .i_b    (rhs),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_carry(w_carry),
    .o_ovf  (w_ovf)
  );

  always_comb begin
    w_out = '0;
    w_of  = 1'b0;
    w_c   = 1'b0;
    case (op)
      ALU_OP_NOP:   w_out = lhs;
      ALU_OP_AND:   w_out = lhs & rhs;
      ALU_OP_OR:    w_out = lhs | rhs;
      ALU_OP_XOR:   w_out = lhs ^ rhs;
      ALU_OP_ADDS, ALU_OP_SUBS: begin
        w_out = w_sum;
        w_of  = w_ovf;
        w_c   = w_carry;
      end
      ALU_OP_ADDU, ALU_OP_SUBU: begin
        w_out = w_sum;
        w_c   = w_carry;
      end
      ALU_OP_SHRL:  w_out = lhs >> w_shamt;
      ALU_OP_SHLL:  w_out = lhs << w_shamt;
      ALU_OP_SHRA:  w_out = w_lhs_s >>> w_shamt;
      // Signed less-than is the true sign of lhs - rhs, corrected for overflow.
      ALU_OP_SLT:   w_out = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
      ALU_OP_SLTU:  w_out = {{(WIDTH-1){1'b0}}, ~w_carry};
      ALU_OP_NOR:   w_out = ~(lhs | rhs);
      ALU_OP_PASSB: w_out = rhs;
      default:      w_out = '0;
    endcase
  end

  assign out   = w_out;
  assign of    = w_of;
  assign flags = {w_out[WIDTH-1], (w_out == '0), w_c, w_of};

  // Stage boundary: flags captured for the following instruction's condition check.
  always_ff @(posedge clk) begin
    if (rst) r_flags_p1 <= 4'b0000;
    else     r_flags_p1 <= flags;
  end

  assign flags_q = r_flags_p1;

endmodule

// File: tb/tb_yutorina_alu.sv
// Directed-vector bench for yutorina_alu with an arithmetic reference model and a per-cycle compare.
module tb_yutorina_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op;
  logic [31:0] lhs, rhs, out;
  logic        of;
  logic [3:0]  flags, flags_q;

  int   n_vec = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;
  logic [3:0] exp_q = 4'b0000;

  logic [31:0] pm_o;
  logic        pm_v;
  logic [3:0]  pm_f;
  logic [31:0] cm_o;
  logic        cm_v;
  logic [3:0]  cm_f;

  yutorina_alu dut (
    .clk    (clk),
    .rst    (rst),
    .op     (op),
    .lhs    (lhs),
    .rhs    (rhs),
    .out    (out),
    .of     (of),
    .flags  (flags),
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] m_op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic v, output logic [3:0] f);
    longint sa, sb, ua, ub, r;
    int     sh;
    logic   c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(b % 32);
    o = 32'h0; v = 1'b0; c = 1'b0;
    case (m_op)
      4'd0:  o = a;
      4'd1:  o = a & b;
      4'd2:  o = a | b;
      4'd3:  o = a ^ b;
      4'd4, 4'd5: begin
        r = ua + ub;
        o = r[31:0];
        c = (r >= 64'sd4294967296);
        if (m_op == 4'd4) v = (sa + sb > 64'sd2147483647) || (sa + sb < -64'sd2147483648);
      end
      4'd6, 4'd7: begin
        r = ua - ub;
        o = r[31:0];
        c = (ua >= ub);
        if (m_op == 4'd6) v = (sa - sb > 64'sd2147483647) || (sa - sb < -64'sd2147483648);
      end
      4'd8:  o = 32'(ua / (64'sd1 << sh));
      4'd9:  o = 32'(ua * (64'sd1 << sh));
      4'd10: begin
        r = sa >>> sh;
        o = r[31:0];
      end
      4'd11: o = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: o = (ua < ub) ? 32'd1 : 32'd0;
      4'd13: o = ~(a | b);
      4'd14: o = b;
      default: o = 32'h0;
    endcase
    f = {o[31], (o == 32'h0), c, v};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (op=%0d lhs=%h rhs=%h)", nm, act, exp, op, lhs, rhs);
    end
  endtask

  always @(posedge clk) begin
    model(op, lhs, rhs, pm_o, pm_v, pm_f);
    exp_q <= rst ? 4'b0000 : pm_f;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      model(op, lhs, rhs, cm_o, cm_v, cm_f);
      check("model_out",     out,           cm_o);
      check("model_of",      32'(of),       32'(cm_v));
      check("model_flags",   32'(flags),    32'(cm_f));
      check("model_flags_q", 32'(flags_q),  32'(exp_q));
    end
  end

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    op = o; lhs = a; rhs = b;
  endtask

  task automatic lit(input string nm, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e_out, input logic e_of, input logic [3:0] e_f);
    drive(o, a, b);
    #1;
    check({nm, "_out"},   out,        e_out);
    check({nm, "_of"},    32'(of),    32'(e_of));
    check({nm, "_flags"}, 32'(flags), 32'(e_f));
  endtask

  logic [31:0] tab_a [6] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'h00000001, 32'h7FFFFFFF};
  logic [31:0] tab_b [6] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000024, 32'h80000000, 32'hFFFFFFE1};

  initial begin
    rst = 1'b1; op = 4'd4; lhs = 32'h7FFFFFFF; rhs = 32'h1;
    @(posedge clk);
    #1;
    check("rst_flags_q", 32'(flags_q), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    check("same_cycle_out", out, 32'h80000000);
    @(posedge clk);
    #1;
    check("ovf_flags_q", 32'(flags_q), 32'h9);

    lit("adds_ovf",  4'd4,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b1, 4'b1001);
    lit("addu",      4'd5,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 4'b1000);
    lit("subs_eq",   4'd6,  32'h5,        32'h5,        32'h0,        1'b0, 4'b0110);
    lit("subu_brw",  4'd7,  32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 4'b1000);
    lit("subs_ovf",  4'd6,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 4'b0011);
    lit("shra",      4'd10, 32'h80000000, 32'h21,       32'hC0000000, 1'b0, 4'b1000);
    lit("shrl",      4'd8,  32'h80000000, 32'h21,       32'h40000000, 1'b0, 4'b0000);
    lit("shll",      4'd9,  32'h1,        32'd31,       32'h80000000, 1'b0, 4'b1000);
    lit("shra_zero", 4'd10, 32'h80000000, 32'h20,       32'h80000000, 1'b0, 4'b1000);
    lit("slt",       4'd11, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 4'b0000);
    lit("sltu",      4'd12, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 4'b0100);
    lit("and",       4'd1,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 4'b1000);
    lit("or",        4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 4'b1000);
    lit("xor",       4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 4'b0000);
    lit("nor",       4'd13, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 4'b0000);
    lit("nop",       4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 4'b1000);
    lit("passb",     4'd14, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFF00FF00, 1'b0, 4'b1000);
    lit("rsvd",      4'd15, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        1'b0, 4'b0100);

    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 6; j++) begin
        drive(4'(k), tab_a[j], tab_b[j]);
      end
    end

    drive(4'd6, 32'h80000000, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_rst_flags_q", 32'(flags_q), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_flags_q", 32'(flags_q), 32'h3);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
